// File: rtl/video_pixel_packer.sv
// Packs a DE/VS framed pixel stream into Avalon-ST words (byte-dense or one pixel per word)
// through a show-ahead FIFO, with frame-start/line-end markers and status counters.
module video_pixel_packer #(
  parameter int unsigned PIXEL_BYTES = 3,
  parameter int unsigned WORD_BYTES  = 4,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [PIXEL_BYTES*8-1:0] pix_data,
  input  logic                     pix_de,
  input  logic                     pix_vs,
  input  logic                     cfg_enable,
  input  logic                     cfg_pad_mode,
  output logic [WORD_BYTES*8-1:0]  st_data,
  output logic                     st_valid,
  output logic                     st_startofpacket,
  output logic                     st_endofpacket,
  input  logic                     st_ready,
  output logic [CNT_WIDTH-1:0]     stat_frames,
  output logic [CNT_WIDTH-1:0]     stat_line_words,
  output logic [CNT_WIDTH-1:0]     stat_overflow
);

  localparam int unsigned WW   = WORD_BYTES * 8;
  localparam int unsigned AW   = (WORD_BYTES + PIXEL_BYTES) * 8;
  localparam int unsigned FW   = $clog2(WORD_BYTES + PIXEL_BYTES + 1);
  localparam int unsigned PTRW = $clog2(FIFO_DEPTH);
  localparam int unsigned EW   = WW + 2;
  localparam logic [FW-1:0] WB_F = FW'(WORD_BYTES);
  localparam logic [FW-1:0] PB_F = FW'(PIXEL_BYTES);

  typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

  state_t               state_q, state_d;
  logic                 vs_q, de_q;
  logic                 pad_q, pad_d;
  logic [AW-1:0]        acc_q, acc_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic                 sop_pend_q, sop_pend_d;
  logic                 stg_valid_q, stg_valid_d;
  logic [WW-1:0]        stg_data_q, stg_data_d;
  logic                 stg_sop_q, stg_sop_d;
  logic [CNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic [EW-1:0]        mem [FIFO_DEPTH];
  logic [PTRW:0]        wr_q, wr_d, rd_q, rd_d;

  logic                 frame_start, line_end, formed;
  logic [AW-1:0]        combined;
  logic [FW-1:0]        fill_sum;
  logic [WW-1:0]        word;
  logic                 push, push_ok, pop, full, drop;
  logic [EW-1:0]        push_entry, head;
  logic                 head_valid;
  logic                 frames_inc, lw_ld;
  logic [CNT_WIDTH-1:0] lw_val;

  // Capture FSM, accumulator, staging and FIFO control
  always_comb begin
    state_d     = state_q;
    pad_d       = pad_q;
    acc_d       = acc_q;
    fill_d      = fill_q;
    sop_pend_d  = sop_pend_q;
    stg_valid_d = stg_valid_q;
    stg_data_d  = stg_data_q;
    stg_sop_d   = stg_sop_q;
    line_cnt_d  = line_cnt_q;
    formed      = 1'b0;
    word        = '0;
    push        = 1'b0;
    push_entry  = '0;
    frames_inc  = 1'b0;
    lw_ld       = 1'b0;
    lw_val      = '0;
    frame_start = pix_vs & ~vs_q;
    line_end    = de_q & ~pix_de;
    combined    = acc_q | (AW'(pix_data) << {fill_q, 3'b000});
    fill_sum    = fill_q + PB_F;

    case (state_q)
      ACTIVE: begin
        if (pix_de) begin
          if (pad_q) begin
            formed = 1'b1;
            word   = WW'(pix_data);
          end else if (fill_sum >= WB_F) begin
            formed = 1'b1;
            word   = combined[WW-1:0];
            acc_d  = combined >> WW;
            fill_d = fill_sum - WB_F;
          end else begin
            acc_d  = combined;
            fill_d = fill_sum;
          end
        end
        if (formed) begin
          if (stg_valid_q) begin
            push       = 1'b1;
            push_entry = {1'b0, stg_sop_q, stg_data_q};
          end
          stg_valid_d = 1'b1;
          stg_data_d  = word;
          stg_sop_d   = sop_pend_q;
          sop_pend_d  = 1'b0;
          line_cnt_d  = line_cnt_q + CNT_WIDTH'(1);
        end else if (line_end) begin
          if (stg_valid_q) begin
            push       = 1'b1;
            push_entry = {(fill_q == '0), stg_sop_q, stg_data_q};
          end
          stg_valid_d = 1'b0;
          if (fill_q != '0) begin
            state_d = FLUSH;
          end else begin
            lw_ld      = 1'b1;
            lw_val     = line_cnt_q;
            line_cnt_d = '0;
          end
        end
      end
      FLUSH: begin
        push       = 1'b1;
        push_entry = {1'b1, sop_pend_q, acc_q[WW-1:0]};
        sop_pend_d = 1'b0;
        acc_d      = '0;
        fill_d     = '0;
        lw_ld      = 1'b1;
        lw_val     = line_cnt_q + CNT_WIDTH'(1);
        line_cnt_d = '0;
        state_d    = ACTIVE;
      end
      default: ;
    endcase

    if (frame_start) begin
      pad_d      = cfg_pad_mode;
      acc_d      = '0;
      fill_d     = '0;
      sop_pend_d = 1'b1;
      line_cnt_d = '0;
      frames_inc = cfg_enable;
      state_d    = cfg_enable ? ACTIVE : IDLE;
    end

    // Show-ahead FIFO; a push into a full FIFO is kept only if a pop frees a slot
    full    = (wr_q[PTRW] != rd_q[PTRW]) && (wr_q[PTRW-1:0] == rd_q[PTRW-1:0]);
    pop     = st_valid && st_ready;
    push_ok = push && (!full || pop);
    drop    = push && !push_ok;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push_ok) wr_d = wr_q + 1'b1;
    if (pop)     rd_d = rd_q + 1'b1;
    head_valid = (wr_d != rd_d);
    if (push_ok && (wr_q[PTRW-1:0] == rd_d[PTRW-1:0])) head = push_entry;
    else                                               head = mem[rd_d[PTRW-1:0]];
    if (!head_valid) head = '0;
  end

  // FIFO storage needs no reset; the registered output head is cleared instead
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q[PTRW-1:0]] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      vs_q             <= 1'b0;
      de_q             <= 1'b0;
      pad_q            <= 1'b0;
      acc_q            <= '0;
      fill_q           <= '0;
      sop_pend_q       <= 1'b0;
      stg_valid_q      <= 1'b0;
      stg_data_q       <= '0;
      stg_sop_q        <= 1'b0;
      line_cnt_q       <= '0;
      wr_q             <= '0;
      rd_q             <= '0;
      st_data          <= '0;
      st_valid         <= 1'b0;
      st_startofpacket <= 1'b0;
      st_endofpacket   <= 1'b0;
      stat_frames      <= '0;
      stat_line_words  <= '0;
      stat_overflow    <= '0;
    end else begin
      state_q          <= state_d;
      vs_q             <= pix_vs;
      de_q             <= pix_de;
      pad_q            <= pad_d;
      acc_q            <= acc_d;
      fill_q           <= fill_d;
      sop_pend_q       <= sop_pend_d;
      stg_valid_q      <= stg_valid_d;
      stg_data_q       <= stg_data_d;
      stg_sop_q        <= stg_sop_d;
      line_cnt_q       <= line_cnt_d;
      wr_q             <= wr_d;
      rd_q             <= rd_d;
      st_data          <= head[WW-1:0];
      st_valid         <= head_valid;
      st_startofpacket <= head[WW];
      st_endofpacket   <= head[WW+1];
      if (frames_inc) stat_frames <= stat_frames + CNT_WIDTH'(1);
      if (lw_ld)      stat_line_words <= lw_val;
      if (drop && (stat_overflow != '1)) stat_overflow <= stat_overflow + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_video_pixel_packer.sv
// Bench for video_pixel_packer: directed and random lines checked against a byte-stream
// reference model (concatenate line bytes, chop into words, mark first/last).
module tb_video_pixel_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] pix_data = '0;
  logic        pix_de = 1'b0;
  logic        pix_vs = 1'b0;
  logic        cfg_enable = 1'b0;
  logic        cfg_pad_mode = 1'b0;
  logic [31:0] st_data;
  logic        st_valid, st_startofpacket, st_endofpacket;
  logic        st_ready = 1'b1;
  logic [15:0] stat_frames, stat_line_words, stat_overflow;

  always #5 clk = ~clk;

  video_pixel_packer #(
    .PIXEL_BYTES(3), .WORD_BYTES(4), .FIFO_DEPTH(16), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .pix_data(pix_data), .pix_de(pix_de), .pix_vs(pix_vs),
    .cfg_enable(cfg_enable), .cfg_pad_mode(cfg_pad_mode),
    .st_data(st_data), .st_valid(st_valid),
    .st_startofpacket(st_startofpacket), .st_endofpacket(st_endofpacket),
    .st_ready(st_ready),
    .stat_frames(stat_frames), .stat_line_words(stat_line_words),
    .stat_overflow(stat_overflow)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [33:0] got_q[$];
  logic [33:0] exp_q[$];
  logic [23:0] line_px[$];
  bit          m_en, m_pad, m_sop, rand_ready;
  int          m_frames, m_line_words;

  // Accepted-word monitor, sampled mid-cycle
  always @(negedge clk)
    if (st_valid && st_ready) got_q.push_back({st_data, st_startofpacket, st_endofpacket});

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vsync(input bit en, input bit pad);
    cfg_enable   = en;
    cfg_pad_mode = pad;
    tick();
    pix_vs = 1'b1;
    tick();
    tick();
    pix_vs = 1'b0;
    tick();
    tick();
    m_en  = en;
    m_pad = pad;
    m_sop = 1'b1;
    if (en) m_frames++;
  endtask

  // Reference: words a line should produce under the latched frame configuration
  task automatic build_expect();
    logic [7:0]  bytes[$];
    logic [31:0] w;
    logic [33:0] words[$];
    int          nw;
    if (!m_en) return;
    if (m_pad) begin
      foreach (line_px[i]) words.push_back({32'(line_px[i]), 2'b00});
    end else begin
      foreach (line_px[i])
        for (int b = 0; b < 3; b++) bytes.push_back(line_px[i][8*b +: 8]);
      nw = (bytes.size() + 3) / 4;
      for (int k = 0; k < nw; k++) begin
        w = '0;
        for (int j = 0; j < 4; j++)
          if (4*k + j < bytes.size()) w[8*j +: 8] = bytes[4*k + j];
        words.push_back({w, 2'b00});
      end
    end
    if (words.size() > 0) begin
      words[0][1] = m_sop;
      m_sop = 1'b0;
      words[words.size()-1][0] = 1'b1;
    end
    m_line_words = words.size();
    foreach (words[i]) exp_q.push_back(words[i]);
  endtask

  task automatic send_line();
    build_expect();
    foreach (line_px[i]) begin
      pix_de   = 1'b1;
      pix_data = line_px[i];
      if (rand_ready) st_ready = 1'($urandom_range(0, 1));
      tick();
    end
    pix_de   = 1'b0;
    pix_data = '0;
    repeat (4) tick();
  endtask

  task automatic rand_line(input int maxlen);
    int n;
    line_px.delete();
    n = $urandom_range(1, maxlen);
    for (int i = 0; i < n; i++) line_px.push_back(24'($urandom));
  endtask

  task automatic drain_check(input string tag);
    int n;
    st_ready = 1'b1;
    repeat (30) tick();
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_word"}, 64'(got_q[i]), 64'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    m_en = 0; m_pad = 0; m_sop = 0; rand_ready = 0; m_frames = 0; m_line_words = 0;

    // Reset state
    repeat (3) tick();
    check("rst_valid", 64'(st_valid), 64'(0));
    check("rst_data", 64'(st_data), 64'(0));
    check("rst_frames", 64'(stat_frames), 64'(0));
    check("rst_line_words", 64'(stat_line_words), 64'(0));
    check("rst_overflow", 64'(stat_overflow), 64'(0));
    rst = 1'b0;
    tick();

    // Packed 3/4: exact 3-word line, then 5-pixel line needing a flush word
    vsync(1'b1, 1'b0);
    line_px = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A};
    send_line();
    drain_check("packed4");
    check("lw_packed4", 64'(stat_line_words), 64'(3));
    line_px = '{24'h030201, 24'h060504, 24'h090807, 24'h0C0B0A, 24'h0F0E0D};
    send_line();
    drain_check("packed5");
    check("lw_packed5", 64'(stat_line_words), 64'(4));
    check("frames1", 64'(stat_frames), 64'(m_frames));

    // Random packed lines with random backpressure, including a new frame
    rand_ready = 1'b1;
    for (int l = 0; l < 8; l++) begin
      if (l == 4) vsync(1'b1, 1'b0);
      rand_line(12);
      send_line();
      drain_check("rnd_packed");
      check("lw_rnd_packed", 64'(stat_line_words), 64'(m_line_words));
    end

    // Pad mode: single-pixel frame, then random pad lines
    rand_ready = 1'b0;
    vsync(1'b1, 1'b1);
    line_px = '{24'h112233};
    send_line();
    drain_check("pad1");
    rand_ready = 1'b1;
    for (int l = 0; l < 4; l++) begin
      rand_line(10);
      send_line();
      drain_check("rnd_pad");
      check("lw_rnd_pad", 64'(stat_line_words), 64'(m_line_words));
    end

    // Overflow: 24 pad words into a 16-deep FIFO with the sink stalled
    rand_ready = 1'b0;
    vsync(1'b1, 1'b1);
    st_ready = 1'b0;
    line_px.delete();
    for (int i = 0; i < 24; i++) line_px.push_back(24'($urandom));
    send_line();
    while (exp_q.size() > 16) void'(exp_q.pop_back());
    repeat (3) tick();
    check("ovf_valid", 64'(st_valid), 64'(1));
    check("ovf_head_hold", 64'({st_data, st_startofpacket, st_endofpacket}), 64'(exp_q[0]));
    check("ovf_count", 64'(stat_overflow), 64'(8));
    check("ovf_line_words", 64'(stat_line_words), 64'(24));
    drain_check("ovf_drain");

    // Enable dropped mid-frame: current frame unaffected, next frame idle
    rand_ready = 1'b1;
    vsync(1'b1, 1'b0);
    cfg_enable = 1'b0;
    rand_line(12);
    send_line();
    drain_check("en_mid");
    vsync(1'b0, 1'b0);
    rand_line(12);
    send_line();
    drain_check("en_off");
    check("frames_frozen", 64'(stat_frames), 64'(m_frames));

    // Asynchronous reset mid-line with two words queued
    rand_ready = 1'b0;
    vsync(1'b1, 1'b0);
    st_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pix_de   = 1'b1;
      pix_data = 24'($urandom);
      tick();
    end
    check("pre_rst_valid", 64'(st_valid), 64'(1));
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 64'(st_valid), 64'(0));
    check("async_rst_frames", 64'(stat_frames), 64'(0));
    check("async_rst_line_words", 64'(stat_line_words), 64'(0));
    check("async_rst_overflow", 64'(stat_overflow), 64'(0));
    #1 rst = 1'b0;
    m_en = 0; m_frames = 0; m_line_words = 0;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      pix_data = 24'($urandom);
      tick();
    end
    pix_de = 1'b0;
    repeat (4) tick();
    drain_check("post_rst_rest");
    rand_line(12);
    send_line();
    drain_check("post_rst_novs");
    vsync(1'b1, 1'b0);
    rand_line(12);
    send_line();
    drain_check("post_rst_resume");
    check("post_rst_frames", 64'(stat_frames), 64'(m_frames));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
